multicycle_sequencer: RTL and testbench



---
 rtl/multicycle_sequencer.sv | 106 ++++++++++
 tb/tb_multicycle_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: instruction fetch, PC ownership and phase stepping for the multicycle RV32 datapath
module multicycle_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              EX_CYC   = 2,
  parameter int              WB_CYC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_rdata,
  input  logic            instr_valid,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic [3:0]      estado,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      tipo,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            retire,
  output logic            illegal
);
  typedef enum logic [3:0] {
    FETCH     = 4'b0000,
    DECODE    = 4'b0001,
    EXECUTE   = 4'b0010,
    MEMORY    = 4'b0011,
    WRITEBACK = 4'b1111,
    TRAP      = 4'b1110
  } state_e;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [3:0] EX_LAST = 4'(EX_CYC - 1);
  localparam logic [3:0] WB_LAST = 4'(WB_CYC - 1);
  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pc_q, pc_d, imm_b;
  logic            taken_q, retire_q, illegal_q, legal, branch_taken;
  always_comb begin
    legal        = ir_q[6:0] inside {OP_IMM, OP_LOAD, OP_REG, OP_BR};
    imm_b        = {{(PC_W-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    branch_taken = (ir_q[14:12] == 3'b000) ? alu_zero : (ir_q[14:12] == 3'b001) ? ~alu_zero : 1'b0;
    pc_d         = taken_q ? pc_q + imm_b : pc_q + PC_W'(4);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0013;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: if (instr_valid) begin
          ir_q    <= instr_rdata;
          state_q <= DECODE;
        end
        DECODE: begin
          cnt_q     <= '0;
          state_q   <= legal ? EXECUTE : TRAP;
          illegal_q <= ~legal;
        end
        EXECUTE: if (cnt_q == EX_LAST) begin
          cnt_q   <= '0;
          taken_q <= (ir_q[6:0] == OP_BR) & branch_taken;
          state_q <= (ir_q[6:0] == OP_LOAD) ? MEMORY : WRITEBACK;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        MEMORY: if (mem_ready) state_q <= WRITEBACK;
        WRITEBACK: if (cnt_q == WB_LAST) begin
          // retire pulse lands in the FETCH cycle that follows the last writeback cycle
          cnt_q    <= '0;
          pc_q     <= pc_d;
          taken_q  <= 1'b0;
          retire_q <= 1'b1;
          state_q  <= FETCH;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        TRAP: illegal_q <= 1'b1;
        default: state_q <= FETCH;
      endcase
    end
  end
  assign estado    = state_q;
  assign instr_req = state_q == FETCH;
  assign pc        = pc_q;
  assign tipo      = ir_q[6:4];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign rd        = ir_q[11:7];
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign retire    = retire_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized and directed checks against a phase-plan reference model
module tb_multicycle_sequencer;
  localparam int EX_CYC = 2, WB_CYC = 2;
  localparam int F = 0, D = 1, E = 2, M = 3, W = 15, T = 14;
  logic        clk = 0, rst_n = 0, instr_valid = 0, alu_zero = 0, mem_ready = 0;
  logic [31:0] instr_rdata = 0;
  logic [3:0]  estado;
  logic        instr_req, retire, illegal;
  logic [31:0] pc;
  logic [2:0]  tipo, funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  int n_f, n_e, n_m, n_w;

  multicycle_sequencer #(.PC_W(32), .RESET_PC(32'h0), .EX_CYC(EX_CYC), .WB_CYC(WB_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .instr_rdata(instr_rdata), .instr_valid(instr_valid),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .estado(estado), .instr_req(instr_req),
    .pc(pc), .tipo(tipo), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Model: on fetch, the whole phase plan of the instruction is queued; MEMORY repeats while not ready
  int          m_est = F;
  logic [31:0] m_pc = 0, m_ir = 32'h13;
  bit          m_ret = 0, m_ill = 0, m_taken = 0;
  int          plan[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      m_est = F; m_pc = 0; m_ir = 32'h13; m_ret = 0; m_ill = 0; m_taken = 0;
      plan.delete();
    end else begin
      m_ret = 0;
      if (m_est == F) begin
        if (instr_valid) begin
          m_ir = instr_rdata;
          plan.push_back(D);
          if (m_ir[6:0] inside {7'b0010011, 7'b0000011, 7'b0110011, 7'b1100011}) begin
            for (int i = 0; i < EX_CYC; i++) plan.push_back(E);
            if (m_ir[6:0] == 7'b0000011) plan.push_back(M);
            for (int i = 0; i < WB_CYC; i++) plan.push_back(W);
          end else plan.push_back(T);
          m_est = plan.pop_front();
        end
      end else if (m_est == T || (m_est == M && !mem_ready)) begin
      end else if (plan.size() == 0) begin
        m_pc    = m_taken ? m_pc + 32'($signed({m_ir[31], m_ir[7], m_ir[30:25], m_ir[11:8], 1'b0})) : m_pc + 4;
        m_taken = 0;
        m_ret   = 1;
        m_est   = F;
      end else begin
        if (m_est == E && plan[0] != E && m_ir[6:0] == 7'b1100011)
          m_taken = (m_ir[14:12] == 0) ? alu_zero : (m_ir[14:12] == 1) ? !alu_zero : 0;
        m_est = plan.pop_front();
        if (m_est == T) m_ill = 1;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    tests++;
    if ({estado, pc, retire, illegal, instr_req, tipo, funct3, funct7, rd, rs1, rs2} !==
        {4'(m_est), m_pc, m_ret, m_ill, m_est == F, m_ir[6:4], m_ir[14:12], m_ir[31:25], m_ir[11:7], m_ir[19:15], m_ir[24:20]}) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t estado=%h/%h pc=%h/%h retire=%b/%b illegal=%b/%b req=%b ir_slices rd=%0d/%0d funct3=%0d/%0d",
               $time, estado, 4'(m_est), pc, m_pc, retire, m_ret, illegal, m_ill, instr_req, rd, m_ir[11:7], funct3, m_ir[14:12]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 0; instr_valid = 0;
    @(negedge clk); #1 rst_n = 1;
  endtask

  // mode 0: run to retire; 1: stay 20 cycles in TRAP; 2: reset during first EXECUTE cycle
  task automatic run(input logic [31:0] ins, input int vd, input int az, input int md, input int mode);
    int mc = 0, tc = 0;
    bit done = 0;
    n_f = 0; n_e = 0; n_m = 0; n_w = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (mode == 0 && k > 0 && m_ret) done = 1;
      else if (mode == 1 && m_est == T && ++tc >= 20) done = 1;
      else if (mode == 2 && m_est == E) begin
        #1 rst_n = 0;
        @(negedge clk); #1 rst_n = 1;
        done = 1;
      end else begin
        n_f += int'(estado == 4'h0); n_e += int'(estado == 4'h2);
        n_m += int'(estado == 4'h3); n_w += int'(estado == 4'hF);
        #1;
        instr_valid = k >= vd;
        instr_rdata = (k >= vd) ? ins : $urandom;
        alu_zero    = (az == 2) ? 1'($urandom) : az[0];
        if (m_est == M) begin mem_ready = mc >= md; mc++; end
        else mem_ready = 1'($urandom);
      end
    end
    instr_valid = 0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL run_timeout instr=%h no completion within 300 cycles", ins);
    end
  endtask

  initial begin
    logic [31:0] r, ins;
    logic [6:0]  op;
    do_reset();
    chk_en = 1;
    check("reset_estado", estado, 0);
    check("reset_pc", pc, 0);
    check("reset_illegal", illegal, 0);
    check("reset_retire", retire, 0);
    run(32'h00500093, 0, 2, 0, 0);
    check("addi_fetch_cycles", n_f, 1);
    check("addi_exec_cycles", n_e, 2);
    check("addi_wb_cycles", n_w, 2);
    check("addi_pc", pc, 4);
    check("addi_retire", retire, 1);
    check("addi_rd", rd, 1);
    check("addi_tipo", tipo, 1);
    do_reset();
    run(32'h00008103, 0, 2, 3, 0);
    check("lb_mem_cycles", n_m, 4);
    check("lb_wb_cycles", n_w, 2);
    check("lb_pc", pc, 4);
    check("lb_rs1", rs1, 1);
    do_reset();
    run(32'h00000863, 0, 1, 0, 0);
    check("beq_taken_pc", pc, 16);
    do_reset();
    run(32'h00000863, 0, 0, 0, 0);
    check("beq_nottaken_pc", pc, 4);
    do_reset();
    run(32'h00500093, 0, 2, 0, 0);
    run(32'h00500093, 0, 2, 0, 0);
    check("bne_start_pc", pc, 8);
    run(32'hFE001CE3, 0, 0, 0, 0);
    check("bne_taken_pc", pc, 0);
    do_reset();
    run(32'h00500093, 0, 2, 0, 0);
    run(32'h00500093, 0, 2, 0, 0);
    run(32'hFE001CE3, 0, 1, 0, 0);
    check("bne_nottaken_pc", pc, 12);
    do_reset();
    run(32'h000000B7, 0, 2, 0, 1);
    check("trap_estado", estado, 14);
    check("trap_illegal", illegal, 1);
    check("trap_req", instr_req, 0);
    check("trap_pc", pc, 0);
    do_reset();
    check("trap_exit_estado", estado, 0);
    check("trap_exit_pc", pc, 0);
    check("trap_exit_illegal", illegal, 0);
    run(32'h00500093, 0, 2, 0, 0);
    run(32'h00000863, 0, 1, 0, 2);
    check("abort_pc", pc, 0);
    check("abort_estado", estado, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_retire", retire, 0);
    end
    run(32'h00500093, 5, 2, 0, 0);
    check("delayed_fetch_cycles", n_f, 6);
    check("delayed_pc", pc, 4);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 14) == 0) do_reset();
      case ($urandom_range(0, 3))
        0: op = 7'b0010011;
        1: op = 7'b0000011;
        2: op = 7'b0110011;
        default: op = 7'b1100011;
      endcase
      r   = $urandom;
      ins = {r[31:7], op};
      run(ins, $urandom_range(0, 3), 2, $urandom_range(0, 3), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
